toy_cpu_pipe: RTL

//   Parametrised 2-stage pipelined successor of the single-cycle toy CPU core.
//   - Accepts one op per cycle over a valid/ready handshake.
//   - Reads a NUM_REGS x DATA_W register file, with bypass from the op in execute.
//   - Delivers every result on a valid/ready output port that supports backpressure.
//   - Sits between the op sequencer (input pins / scan loader) and the output mux.

---
 rtl/toy_cpu_pipe_if.sv | 29 ++
 rtl/toy_cpu_pipe.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/toy_cpu_pipe_if.sv
// Op-issue and result handshake bundle for toy_cpu_pipe.
// master = op sequencer / result consumer side, slave = the core.
interface toy_cpu_pipe_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8
);
    localparam int AW = $clog2(NUM_REGS);

    logic              op_valid;
    logic              op_ready;
    logic [2:0]        opcode;
    logic [AW-1:0]     src_a;
    logic [AW-1:0]     src_b;
    logic [AW-1:0]     dest;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output op_valid, opcode, src_a, src_b, dest, imm, out_ready,
        input  op_ready, out, out_valid
    );

    modport slave (
        input  op_valid, opcode, src_a, src_b, dest, imm, out_ready,
        output op_ready, out, out_valid
    );
endinterface

// File: rtl/toy_cpu_pipe.sv
// Two-stage (decode / result) pipelined toy CPU with register bypass and output backpressure.
// Optional zero/carry flag outputs are built when TOY_CPU_PIPE_FLAGS_EN is defined.
module toy_cpu_pipe #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8
) (
    input  logic             clk,
    input  logic             rst,
    toy_cpu_pipe_if.slave    bus
`ifdef TOY_CPU_PIPE_FLAGS_EN
    ,
    output logic             zero,
    output logic             carry
`endif
);
    localparam int AW = $clog2(NUM_REGS);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SUBI = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_XORI = 3'b110;
    localparam logic [2:0] OP_LI   = 3'b111;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic              d_valid_q, d_valid_d;
    logic [2:0]        d_op_q,    d_op_d;
    logic [AW-1:0]     d_dest_q,  d_dest_d;
    logic [DATA_W-1:0] d_a_q,     d_a_d;
    logic [DATA_W-1:0] d_b_q,     d_b_d;

    logic              r_valid_q, r_valid_d;
    logic [DATA_W-1:0] r_out_q,   r_out_d;

    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic              r_load;
    logic              d_move;
    logic              d_writes;
    logic              reg_we;
    logic              b_from_reg;
    logic              op_ready;
    logic              accept;

    // Execute: the D stage result feeds both R and the bypass path.
    always_comb begin
        alu_res = '0;
        case (d_op_q)
            OP_NOP:          alu_res = '0;
            OP_ADD, OP_ADDI: alu_res = d_a_q + d_b_q;
            OP_SUB, OP_SUBI: alu_res = d_a_q - d_b_q;
            OP_XOR, OP_XORI: alu_res = d_a_q ^ d_b_q;
            OP_LI:           alu_res = d_b_q;
            default:         alu_res = '0;
        endcase
    end

    assign r_load   = !r_valid_q || bus.out_ready;
    assign d_move   = d_valid_q && r_load;
    assign d_writes = d_valid_q && (d_op_q != OP_NOP);
    assign reg_we   = d_move && (d_op_q != OP_NOP);
    assign op_ready = !rst && (!d_valid_q || d_move);
    assign accept   = bus.op_valid && op_ready;

    // LI is odd-coded but takes its value from imm, carried through the B slot.
    assign b_from_reg = bus.opcode[0] && (bus.opcode != OP_LI);

    always_comb begin
        opnd_a = regs_q[bus.src_a];
        if (d_writes && (d_dest_q == bus.src_a)) begin
            opnd_a = alu_res;
        end
        opnd_b = bus.imm;
        if (b_from_reg) begin
            opnd_b = regs_q[bus.src_b];
            if (d_writes && (d_dest_q == bus.src_b)) begin
                opnd_b = alu_res;
            end
        end
    end

    always_comb begin
        d_valid_d = d_valid_q;
        d_op_d    = d_op_q;
        d_dest_d  = d_dest_q;
        d_a_d     = d_a_q;
        d_b_d     = d_b_q;
        r_valid_d = r_valid_q;
        r_out_d   = r_out_q;
        if (accept) begin
            d_valid_d = 1'b1;
            d_op_d    = bus.opcode;
            d_dest_d  = bus.dest;
            d_a_d     = opnd_a;
            d_b_d     = opnd_b;
        end else if (d_move) begin
            d_valid_d = 1'b0;
        end
        if (r_load) begin
            r_valid_d = d_valid_q;
            if (d_valid_q) begin
                r_out_d = alu_res;
            end
        end
    end

    // Writeback happens in the same cycle the op leaves D for R.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regfile
        assign regs_d[gi] = (reg_we && (d_dest_q == AW'(gi))) ? alu_res : regs_q[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            d_valid_q <= 1'b0;
            d_op_q    <= '0;
            d_dest_q  <= '0;
            d_a_q     <= '0;
            d_b_q     <= '0;
            r_valid_q <= 1'b0;
            r_out_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            d_valid_q <= d_valid_d;
            d_op_q    <= d_op_d;
            d_dest_q  <= d_dest_d;
            d_a_q     <= d_a_d;
            d_b_q     <= d_b_d;
            r_valid_q <= r_valid_d;
            r_out_q   <= r_out_d;
        end
    end

    assign bus.op_ready  = op_ready;
    assign bus.out       = r_out_q;
    assign bus.out_valid = r_valid_q;

`ifdef TOY_CPU_PIPE_FLAGS_EN
    logic alu_carry;
    logic zero_q,  zero_d;
    logic carry_q, carry_d;

    // Add carry-out shows up as a wrapped sum; subtract borrow is A<B unsigned.
    always_comb begin
        alu_carry = 1'b0;
        case (d_op_q)
            OP_ADD, OP_ADDI: alu_carry = (alu_res < d_a_q);
            OP_SUB, OP_SUBI: alu_carry = (d_a_q < d_b_q);
            default:         alu_carry = 1'b0;
        endcase
    end

    always_comb begin
        zero_d  = zero_q;
        carry_d = carry_q;
        if (d_move) begin
            zero_d  = (alu_res == '0);
            carry_d = alu_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign zero  = zero_q;
    assign carry = carry_q;
`endif
endmodule
